if_id_queue: RTL and testbench

Parametrised successor to the single-register IF/ID stage: a DEPTH-entry in-order instruction queue between fetch and decode. It uses valid/ready handshakes on both sides, supports a pipeline flush, and injects a NOP whenever it is empty. Fetch can keep running while decode is stalled, and stalls stay local to the stage boundary.

---
 rtl/if_id_queue.sv | 66 ++++++
 tb/tb_if_id_queue.sv | 121 ++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry in-order IF/ID instruction queue with valid/ready, flush and NOP injection.
// Optional macro IFIDQ_FAULT_EN adds a per-entry fetch access-fault bit (fault_i_IFIDQ/fault_o_IFIDQ).
module if_id_queue #(
   parameter int                   INSTR_W   = 32,
   parameter int                   ADDR_W    = 32,
   parameter int                   DEPTH     = 2,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000013,
   parameter logic [ADDR_W-1:0]    RST_PC    = 32'h00000000
) (
   input  logic                         clk_i_IFIDQ,
   input  logic                         rst_i_IFIDQ,
   input  logic [INSTR_W-1:0]           instr_i_IFIDQ,
   input  logic [ADDR_W-1:0]            pc_addr_i_IFIDQ,
   input  logic                         valid_i_IFIDQ,
   output logic                         ready_o_IFIDQ,
   input  logic                         flush_i_IFIDQ,
`ifdef IFIDQ_FAULT_EN
   input  logic                         fault_i_IFIDQ,
   output logic                         fault_o_IFIDQ,
`endif
   output logic [INSTR_W-1:0]           instr_o_IFIDQ,
   output logic [ADDR_W-1:0]            pc_addr_o_IFIDQ,
   output logic                         valid_o_IFIDQ,
   input  logic                         ready_i_IFIDQ,
   output logic [$clog2(DEPTH+1)-1:0]   count_o_IFIDQ
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [INSTR_W-1:0] mem_instr [DEPTH];
   logic [ADDR_W-1:0]  mem_pc    [DEPTH];
   logic [PW-1:0]      rd_ptr, wr_ptr;
   logic [CW-1:0]      count;
   logic               push, pop;
   assign ready_o_IFIDQ = count != CW'(DEPTH);
   assign valid_o_IFIDQ = count != '0;
   assign push = valid_i_IFIDQ && ready_o_IFIDQ;
   assign pop  = valid_o_IFIDQ && ready_i_IFIDQ;
   assign count_o_IFIDQ = count;
   assign instr_o_IFIDQ   = valid_o_IFIDQ ? mem_instr[rd_ptr] : NOP_INSTR;
   assign pc_addr_o_IFIDQ = valid_o_IFIDQ ? mem_pc[rd_ptr]    : RST_PC;
   always_ff @(posedge clk_i_IFIDQ) begin
      if (!rst_i_IFIDQ || flush_i_IFIDQ) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   // payload storage needs no reset: valid_o masks stale entries
   always_ff @(posedge clk_i_IFIDQ) begin
      if (push) begin
         mem_instr[wr_ptr] <= instr_i_IFIDQ;
         mem_pc[wr_ptr]    <= pc_addr_i_IFIDQ;
      end
   end
`ifdef IFIDQ_FAULT_EN
   logic mem_fault [DEPTH];
   always_ff @(posedge clk_i_IFIDQ) begin
      if (push) mem_fault[wr_ptr] <= fault_i_IFIDQ;
   end
   assign fault_o_IFIDQ = valid_o_IFIDQ && mem_fault[rd_ptr];
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: scoreboard bench for if_id_queue; outputs compared each cycle against a queue model.
module tb_if_id_queue;
   localparam int DEPTH = 2;
   logic        clk = 0;
   logic        rst, valid_i, ready_i, flush_i;
   logic [31:0] instr_i, pc_i, instr_o, pc_o;
   logic        ready_o, valid_o;
   logic [1:0]  count_o;
`ifdef IFIDQ_FAULT_EN
   logic        fault_i, fault_o;
`endif
   typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic f;} ent_t;
   ent_t sb[$];
   int   n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   if_id_queue #(.DEPTH(DEPTH)) dut (
      .clk_i_IFIDQ(clk), .rst_i_IFIDQ(rst),
      .instr_i_IFIDQ(instr_i), .pc_addr_i_IFIDQ(pc_i),
      .valid_i_IFIDQ(valid_i), .ready_o_IFIDQ(ready_o), .flush_i_IFIDQ(flush_i),
`ifdef IFIDQ_FAULT_EN
      .fault_i_IFIDQ(fault_i), .fault_o_IFIDQ(fault_o),
`endif
      .instr_o_IFIDQ(instr_o), .pc_addr_o_IFIDQ(pc_o),
      .valid_o_IFIDQ(valid_o), .ready_i_IFIDQ(ready_i), .count_o_IFIDQ(count_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // compare at negedge, then advance the model on the rising edge
   task automatic tick();
      logic   m_push, m_pop, f_in;
      ent_t   e;
      @(negedge clk);
      check("valid_o", 64'(valid_o), 64'(sb.size() != 0));
      check("ready_o", 64'(ready_o), 64'(sb.size() != DEPTH));
      check("count_o", 64'(count_o), 64'(sb.size()));
      check("pc_o",    64'(pc_o),    sb.size() != 0 ? 64'(sb[0].pc)    : 64'h0);
      check("instr_o", 64'(instr_o), sb.size() != 0 ? 64'(sb[0].instr) : 64'h13);
      f_in = 1'b0;
`ifdef IFIDQ_FAULT_EN
      check("fault_o", 64'(fault_o), sb.size() != 0 ? 64'(sb[0].f) : 64'h0);
      f_in = fault_i;
`endif
      m_push = valid_i && sb.size() != DEPTH;
      m_pop  = ready_i && sb.size() != 0;
      e = '{pc: pc_i, instr: instr_i, f: f_in};
      @(posedge clk);
      if (!rst || flush_i) sb.delete();
      else begin
         if (m_pop) void'(sb.pop_front());
         if (m_push) sb.push_back(e);
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic r, input logic [31:0] pc, input logic [31:0] ins);
      valid_i = v; ready_i = r; pc_i = pc; instr_i = ins;
      tick();
   endtask

   initial begin
      rst = 0; flush_i = 0; valid_i = 1; ready_i = 0; pc_i = 0; instr_i = 32'hDEADBEEF;
`ifdef IFIDQ_FAULT_EN
      fault_i = 0;
`endif
      @(posedge clk); #1;
      tick(); tick();
      rst = 1;
      drive(0, 0, 0, 0);
      // fill and stall, third push refused
      drive(1, 0, 32'h100, 32'h00500093);
      drive(1, 0, 32'h104, 32'h00A00113);
      drive(1, 0, 32'h108, 32'h00000000);
      drive(0, 0, 0, 0);
      // drain in order
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
      // streaming with wrap
      for (int i = 0; i < 12; i++) drive(1, 1, 32'(4 * i), 32'h1000 + 32'(i));
      drive(0, 1, 0, 0);
      // flush full queue with concurrent push
      drive(1, 0, 32'h200, 32'hA0);
      drive(1, 0, 32'h204, 32'hA4);
      flush_i = 1; drive(1, 1, 32'h208, 32'hA8); flush_i = 0;
      drive(1, 0, 32'h300, 32'hB0);
      drive(0, 0, 0, 0);
      // flush one-entry queue with an accepted push
      flush_i = 1; drive(1, 1, 32'h20C, 32'hAC); flush_i = 0;
      drive(0, 0, 0, 0);
      // reset together with flush while full
      drive(1, 0, 32'h400, 32'hC0);
      drive(1, 0, 32'h404, 32'hC4);
      rst = 0; flush_i = 1; drive(1, 1, 32'h408, 32'hC8);
      rst = 1; flush_i = 0; drive(0, 0, 0, 0);
`ifdef IFIDQ_FAULT_EN
      fault_i = 0; drive(1, 0, 32'h500, 32'hD0);
      fault_i = 1; drive(1, 1, 32'h504, 32'hD4);
      fault_i = 0; drive(1, 1, 32'h508, 32'hD8);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
`endif
      // random traffic
      for (int i = 0; i < 300; i++) begin
         flush_i = ($urandom_range(0, 19) == 0);
`ifdef IFIDQ_FAULT_EN
         fault_i = 1'($urandom_range(0, 1));
`endif
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      flush_i = 0;
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
